debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised multi-channel switch conditioner for front-panel buttons and toggles.
- Each of N channels gets its own synchroniser, a debounce counter that restarts on any bounce, and registered rise/fall pulses.
- Each channel also has long-press (hold) detection with optional auto-repeat.
- Sits between the board pins and the control/UI logic, clocked by the system clock and paced by the shared slow (1 ms) clock enable.

Parameters:
- CHANNELS, 8, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2), clocked every clock, not gated by clken.
- MAX_COUNT, 16, consecutive clken ticks of disagreement needed to change out (>=2).
- HOLD_COUNT, 500, clken ticks out must stay high, after its rise commit, before hold asserts (>=1).
- REPEAT_COUNT, 100, clken ticks between auto-repeat pulses once held (>=1).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- clken  input  1  slow tick enable, one clock wide; paces debounce, hold and repeat counters.
- repeat_en  input  CHANNELS  per-channel auto-repeat enable.
- in  input  CHANNELS  raw noisy asynchronous inputs.
- out  output  CHANNELS  debounced, synchronised level.
- out_rise  output  CHANNELS  one-clock pulse when out goes 0->1.
- out_fall  output  CHANNELS  one-clock pulse when out goes 1->0.
- out_hold  output  CHANNELS  level: out has been high for >= HOLD_COUNT ticks.
- out_repeat  output  CHANNELS  one-clock pulse at hold onset, then every REPEAT_COUNT ticks while held and repeat_en=1.
- any_event  output  1  registered OR of all out_rise|out_fall bits, same cycle as those pulses.

Behaviour:
- Reset (async assert, synchronous release by the clock domain): sync flops, out, out_rise, out_fall, out_hold, out_repeat, any_event = 0; all counters = 0.
- Channels are fully independent. Any number may commit, hold or repeat in the same cycle.
- s = in after SYNC_STAGES flops.
- Debounce counter width is $clog2(MAX_COUNT). Rules on a clock with clken=1:
  - s == out: counter <= 0. Any bounce fully restarts the count, unlike a non-restarting accumulator.
  - s != out and counter == MAX_COUNT-1: out <= s, counter <= 0. out_rise (s=1) or out_fall (s=0) is asserted on the same edge.
  - otherwise: counter <= counter + 1.
- Latency: out changes on the MAX_COUNT-th consecutive disagreeing clken tick. Counted from the in edge, that is SYNC_STAGES clocks plus MAX_COUNT ticks.
- out_rise, out_fall, out_repeat and any_event are registered pulses, exactly one clock wide. They default to 0 on every clock.
- Hold counter hc is a saturating counter of width $clog2(HOLD_COUNT+1):
  - Cleared whenever out=0, including on the rise-commit edge itself.
  - On clken with out=1 and hc < HOLD_COUNT: hc <= hc + 1.
  - When hc becomes HOLD_COUNT: out_hold <= 1, out_repeat pulses once (regardless of repeat_en), repeat counter rc <= 0.
- Repeat: while out_hold=1, on each clken, rc <= rc + 1. When rc == REPEAT_COUNT-1: rc <= 0 and out_repeat pulses if repeat_en=1. rc keeps running when repeat_en=0, so the repeat phase is preserved.
- Fall commit: out_hold, hc and rc clear on the same edge that out falls. No repeat pulse is issued on that edge.
- clken=0: no counter or out change. Synchroniser flops still shift.
- Reset mid-count or mid-hold: everything clears. With in held high through the release, a fresh out_rise follows SYNC_STAGES clocks plus MAX_COUNT ticks later.
- clken asserted on consecutive clocks is legal. Each asserted clock counts as one tick.

Test Plan (CHANNELS=4, MAX_COUNT=4, HOLD_COUNT=6, REPEAT_COUNT=3, SYNC_STAGES=2, clken every 4th clock):
- Clean press: in[0] 0->1 and held -> out[0]=1 on the 4th clken after s[0] goes high. out_rise[0] and any_event high for exactly 1 clock. Other channels stay 0.
- Bounce restart: in[1] high for 3 ticks, low for 1 tick, then high -> no commit until 4 further consecutive high ticks. Exactly one out_rise[1].
- Hold/repeat: in[2] held with repeat_en[2]=1 -> out_hold[2] and out_repeat[2] 6 ticks after the rise commit, then out_repeat pulses every 3 ticks. Release -> out_fall[2], and out_hold[2]=0 on the same edge.
- Repeat disabled: same as above with repeat_en[2]=0 -> only the hold-onset repeat pulse occurs. Setting repeat_en=1 later resumes pulses on the preserved rc phase.
- Simultaneous: in[0] and in[3] commit on the same tick -> both out_rise bits high in the same clock, and a single any_event pulse.
- Reset mid-hold: assert reset while out_hold[2]=1 with in[2] still high -> all outputs 0 immediately. After release, out_rise[2] occurs 2 clocks plus 4 ticks later, and out_hold returns 6 ticks after that.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel input synchroniser, restart-on-bounce debouncer,
// registered edge pulses, and long-press hold detection with optional auto-repeat.
module debounce_bank #(
  parameter int CHANNELS     = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_COUNT    = 16,
  parameter int HOLD_COUNT   = 500,
  parameter int REPEAT_COUNT = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clken,
  input  logic [CHANNELS-1:0] repeat_en,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] out_rise,
  output logic [CHANNELS-1:0] out_fall,
  output logic [CHANNELS-1:0] out_hold,
  output logic [CHANNELS-1:0] out_repeat,
  output logic                any_event
);

  localparam int DW = $clog2(MAX_COUNT);
  localparam int HW = $clog2(HOLD_COUNT + 1);
  // One extra bit keeps the repeat counter non-empty when REPEAT_COUNT is 1.
  localparam int RW = $clog2(REPEAT_COUNT + 1);

  localparam logic [DW-1:0] CNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);
  localparam logic [DW-1:0] CNT_LAST = DW'(MAX_COUNT - 1);
  localparam logic [HW-1:0] HC_ZERO  = {HW{1'b0}};
  localparam logic [HW-1:0] HC_ONE   = HW'(1);
  localparam logic [HW-1:0] HC_LAST  = HW'(HOLD_COUNT - 1);
  localparam logic [RW-1:0] RC_ZERO  = {RW{1'b0}};
  localparam logic [RW-1:0] RC_ONE   = RW'(1);
  localparam logic [RW-1:0] RC_LAST  = RW'(REPEAT_COUNT - 1);

  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_s;

  logic [DW-1:0] cnt_r    [CHANNELS];
  logic [DW-1:0] cnt_nx_s [CHANNELS];
  logic [HW-1:0] hc_r     [CHANNELS];
  logic [HW-1:0] hc_nx_s  [CHANNELS];
  logic [RW-1:0] rc_r     [CHANNELS];
  logic [RW-1:0] rc_nx_s  [CHANNELS];

  logic [CHANNELS-1:0] out_r,  out_nx_s;
  logic [CHANNELS-1:0] rise_r, rise_nx_s;
  logic [CHANNELS-1:0] fall_r, fall_nx_s;
  logic [CHANNELS-1:0] hold_r, hold_nx_s;
  logic [CHANNELS-1:0] rep_r,  rep_nx_s;
  logic                any_r,  any_nx_s;

  assign sync_s     = sync_r[SYNC_STAGES-1];
  assign out        = out_r;
  assign out_rise   = rise_r;
  assign out_fall   = fall_r;
  assign out_hold   = hold_r;
  assign out_repeat = rep_r;
  assign any_event  = any_r;

  // Synchroniser chain, shifts every clock regardless of clken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {CHANNELS{1'b0}};
      end
    end else begin
      sync_r[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Next-state for debounce, hold and repeat per channel
  always_comb begin
    any_nx_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nx_s[i]  = cnt_r[i];
      out_nx_s[i]  = out_r[i];
      rise_nx_s[i] = 1'b0;
      fall_nx_s[i] = 1'b0;
      hc_nx_s[i]   = hc_r[i];
      rc_nx_s[i]   = rc_r[i];
      hold_nx_s[i] = hold_r[i];
      rep_nx_s[i]  = 1'b0;

      if (!clken) begin
        cnt_nx_s[i] = cnt_r[i];
      end else if (sync_s[i] == out_r[i]) begin
        cnt_nx_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        out_nx_s[i]  = sync_s[i];
        cnt_nx_s[i]  = CNT_ZERO;
        rise_nx_s[i] = sync_s[i];
        fall_nx_s[i] = ~sync_s[i];
      end else begin
        cnt_nx_s[i] = cnt_r[i] + CNT_ONE;
      end

      // A falling commit wins over any repeat tick on the same edge
      if (!out_r[i] || fall_nx_s[i]) begin
        hc_nx_s[i]   = HC_ZERO;
        rc_nx_s[i]   = RC_ZERO;
        hold_nx_s[i] = 1'b0;
      end else if (!clken) begin
        hc_nx_s[i] = hc_r[i];
      end else if (hold_r[i]) begin
        if (rc_r[i] == RC_LAST) begin
          rc_nx_s[i]  = RC_ZERO;
          rep_nx_s[i] = repeat_en[i];
        end else begin
          rc_nx_s[i] = rc_r[i] + RC_ONE;
        end
      end else begin
        hc_nx_s[i] = hc_r[i] + HC_ONE;
        if (hc_r[i] == HC_LAST) begin
          hold_nx_s[i] = 1'b1;
          rep_nx_s[i]  = 1'b1;
          rc_nx_s[i]   = RC_ZERO;
        end else begin
          hold_nx_s[i] = 1'b0;
        end
      end
    end
    any_nx_s = |(rise_nx_s | fall_nx_s);
  end

  // Channel counters and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= CNT_ZERO;
        hc_r[i]  <= HC_ZERO;
        rc_r[i]  <= RC_ZERO;
      end
      out_r  <= {CHANNELS{1'b0}};
      rise_r <= {CHANNELS{1'b0}};
      fall_r <= {CHANNELS{1'b0}};
      hold_r <= {CHANNELS{1'b0}};
      rep_r  <= {CHANNELS{1'b0}};
      any_r  <= 1'b0;
    end else begin
      cnt_r  <= cnt_nx_s;
      hc_r   <= hc_nx_s;
      rc_r   <= rc_nx_s;
      out_r  <= out_nx_s;
      rise_r <= rise_nx_s;
      fall_r <= fall_nx_s;
      hold_r <= hold_nx_s;
      rep_r  <= rep_nx_s;
      any_r  <= any_nx_s;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: tick-level vector table for debounce/hold/repeat, plus a
// hand-written reset-during-hold sequence.
module tb_debounce_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic       clken;
  logic [3:0] ren;
  logic [3:0] din;
  logic [3:0] out, out_rise, out_fall, out_hold, out_repeat;
  logic       any_event;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .MAX_COUNT(4), .HOLD_COUNT(6), .REPEAT_COUNT(3)
  ) dut (
    .clock(clock), .reset(reset), .clken(clken), .repeat_en(ren), .in(din),
    .out(out), .out_rise(out_rise), .out_fall(out_fall), .out_hold(out_hold),
    .out_repeat(out_repeat), .any_event(any_event)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] in_v;
    logic [3:0] ren_v;
    logic [3:0] out_v;
    logic [3:0] rise_v;
    logic [3:0] fall_v;
    logic [3:0] hold_v;
    logic [3:0] rep_v;
    logic       any_v;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic [3:0] i_v, input logic [3:0] r_v,
                     input logic [3:0] o_v, input logic [3:0] ri_v, input logic [3:0] fa_v,
                     input logic [3:0] h_v, input logic [3:0] rp_v, input logic a_v);
    vec_t v;
    v.in_v = i_v; v.ren_v = r_v; v.out_v = o_v; v.rise_v = ri_v;
    v.fall_v = fa_v; v.hold_v = h_v; v.rep_v = rp_v; v.any_v = a_v;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // One tick = 4 clocks, clken on the last; sample #1 after the clken edge.
  // The first clock of every tick also confirms the previous pulses were one clock wide.
  task automatic run_tick(input string tag, input logic [3:0] i_v, input logic [3:0] r_v);
    din = i_v;
    ren = r_v;
    for (int c = 0; c < 4; c++) begin
      clken = (c == 3);
      @(posedge clock);
      #1;
      if (c == 0) begin
        check({tag, " pulses cleared"}, out_rise | out_fall | out_repeat | {3'b000, any_event}, 4'b0000);
      end
    end
    clken = 1'b0;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " out"},        out,        v.out_v);
    check({tag, " out_rise"},   out_rise,   v.rise_v);
    check({tag, " out_fall"},   out_fall,   v.fall_v);
    check({tag, " out_hold"},   out_hold,   v.hold_v);
    check({tag, " out_repeat"}, out_repeat, v.rep_v);
    check({tag, " any_event"},  {3'b000, any_event}, {3'b000, v.any_v});
  endtask

  task automatic tick_check(input string tag, input vec_t v);
    run_tick(tag, v.in_v, v.ren_v);
    check_all(tag, v);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    clken = 1'b0;
    din   = 4'b0000;
    ren   = 4'b0000;

    //      n  in       ren      out      rise     fall     hold     rep      any
    add(2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t0-1 idle
    add(3, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t2-4 press ch0, ch1
    add(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1); // t5 ch0 commits, ch1 bounces
    add(1, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t6 ch1 restarts
    add(2, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t7-8 ch0 released
    add(1, 4'b0010, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1); // t9 ch1 commits
    add(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1); // t10 ch0 falls
    add(3, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t11-13
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b1); // t14 ch1 falls
    add(3, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t15-17
    add(1, 4'b1001, 4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b1); // t18 simultaneous rise
    add(3, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t19-21
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 1'b1); // t22 simultaneous fall
    add(3, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t23-25
    add(1, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1); // t26 ch2 rise
    add(5, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0); // t27-31
    add(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0); // t32 hold onset
    add(2, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0); // t33-34
    add(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0); // t35 repeat
    add(2, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0); // t36-37
    add(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0); // t38 repeat
    add(6, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0); // t39-44 repeat off
    add(2, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0); // t45-46
    add(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0); // t47 phase kept
    add(2, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0); // t48-49
    add(1, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0); // t50 repeat, released
    add(2, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0); // t51-52
    add(1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1); // t53 fall, no repeat

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    v = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    check_all("reset", v);
    reset = 1'b0;

    foreach (vecs[i]) begin
      tick_check($sformatf("t%0d", i), vecs[i]);
    end

    // Hold with repeat disabled still gives the onset pulse
    for (int k = 0; k < 3; k++) begin
      v = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tick_check($sformatf("u%0d", k), v);
    end
    v = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tick_check("u3 rise", v);
    for (int k = 4; k < 9; k++) begin
      v = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tick_check($sformatf("u%0d", k), v);
    end
    v = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0};
    tick_check("u9 hold onset", v);
    v = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0};
    tick_check("u10 held", v);

    // Reset mid-hold clears outputs without waiting for a clock edge
    reset = 1'b1;
    #2;
    v = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    check_all("async reset", v);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      v = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tick_check($sformatf("r%0d", k), v);
    end
    v = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tick_check("r3 rise after reset", v);
    for (int k = 4; k < 9; k++) begin
      v = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tick_check($sformatf("r%0d", k), v);
    end
    v = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b0};
    tick_check("r9 hold after reset", v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
